// File: rtl/riscv_dmi_engine_if.sv
// Request/response channel between the DMI transaction engine (master) and
// the Debug Module (slave).
interface riscv_dmi_engine_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [1:0]            req_op;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [1:0]            resp_op;

  modport master (
    output req_valid, req_addr, req_data, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_op
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_op
  );
endinterface

// File: rtl/riscv_dmi_engine.sv
// DMI transaction engine: queues scan-update commands, issues them in order to
// the Debug Module, and keeps the sticky dmistat / capture view with timeout.
module riscv_dmi_engine #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = $clog2(REQ_DEPTH + 2)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_addr_i,
  input  logic [DATA_WIDTH-1:0] upd_data_i,
  input  logic [1:0]            upd_op_i,
  input  logic                  cap_i,
  output logic [DATA_WIDTH-1:0] cap_data_o,
  output logic [1:0]            cap_op_o,
  input  logic                  dmireset_i,
  input  logic                  hardreset_i,
  riscv_dmi_engine_if.master    dmi,
  output logic [1:0]            dmistat_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  pending_o
);

  localparam int PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]        TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] DEPTH    = CNT_WIDTH'(REQ_DEPTH);
  localparam logic [PW-1:0]        PTR_LAST = PW'(REQ_DEPTH - 1);

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_FAILED = 2'd2;
  localparam logic [1:0] ST_BUSY   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] q_addr  [REQ_DEPTH];
  logic [DATA_WIDTH-1:0] q_data  [REQ_DEPTH];
  logic                  q_write [REQ_DEPTH];

  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [1:0]            sticky_q, sticky_d;
  logic [1:0]            last_op_q;
  logic [DATA_WIDTH-1:0] last_data_q;
  logic [TW-1:0]         timer_q;

  logic in_flight, q_full, upd_cmd, upd_rw, upd_rsvd, upd_full;
  logic push, pop, resp_hit, timeout, cap_err;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign in_flight = (state_q != S_IDLE);
  assign q_full    = (count_q == DEPTH);
  assign pop       = (state_q == S_REQ) && dmi.req_ready;

  // A full queue still accepts a command when the head leaves in the same cycle.
  assign upd_cmd  = upd_valid_i && (sticky_q == ST_OK);
  assign upd_rw   = (upd_op_i == OP_READ) || (upd_op_i == OP_WRITE);
  assign upd_rsvd = upd_cmd && (upd_op_i == OP_RSVD);
  assign upd_full = upd_cmd && upd_rw && q_full && !pop;
  assign push     = upd_cmd && upd_rw && !(q_full && !pop);

  assign resp_hit = (state_q == S_WAIT) && dmi.resp_valid;
  assign timeout  = (TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) && !dmi.resp_valid &&
                    (timer_q == TMO_LAST);
  assign cap_err  = cap_i && busy_o && (sticky_q == ST_OK);

  assign busy_o     = (count_q != '0) || in_flight;
  assign pending_o  = count_q + CNT_WIDTH'(in_flight);
  assign dmistat_o  = sticky_q;
  assign cap_data_o = last_data_q;
  assign cap_op_o   = (sticky_q != ST_OK) ? sticky_q :
                      busy_o              ? ST_BUSY  : last_op_q;

  // First error since the last dmireset is the one that sticks.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_q == ST_OK) begin
      if (resp_hit && (dmi.resp_op != ST_OK)) sticky_d = dmi.resp_op;
      else if (timeout)                       sticky_d = ST_FAILED;
      else if (upd_rsvd)                      sticky_d = ST_FAILED;
      else if (upd_full)                      sticky_d = ST_BUSY;
      else if (cap_err)                       sticky_d = ST_BUSY;
    end
    if (dmireset_i) sticky_d = ST_OK;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else if (hardreset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_REQ;
      S_REQ:   if (dmi.req_ready) state_d = S_WAIT;
      S_WAIT:  if (resp_hit || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmi.req_valid  = 1'b0;
    dmi.req_addr   = '0;
    dmi.req_data   = '0;
    dmi.req_op     = '0;
    dmi.resp_ready = 1'b1;
    case (state_q)
      S_REQ: begin
        dmi.req_valid  = 1'b1;
        dmi.req_addr   = q_addr[rd_ptr_q];
        dmi.req_data   = q_data[rd_ptr_q];
        dmi.req_op     = q_write[rd_ptr_q] ? OP_WRITE : OP_READ;
        dmi.resp_ready = 1'b0;
      end
      default: ;
    endcase
  end

  // Queue storage holds no control meaning, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_addr[wr_ptr_q]  <= upd_addr_i;
      q_data[wr_ptr_q]  <= upd_data_i;
      q_write[wr_ptr_q] <= (upd_op_i == OP_WRITE);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sticky_q    <= ST_OK;
      last_op_q   <= ST_OK;
      last_data_q <= '0;
      timer_q     <= '0;
    end else if (hardreset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sticky_q    <= ST_OK;
      last_op_q   <= ST_OK;
      last_data_q <= '0;
      timer_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
      sticky_q <= sticky_d;
      if (resp_hit) begin
        last_data_q <= dmi.resp_data;
        last_op_q   <= dmi.resp_op;
      end else if (timeout) begin
        last_op_q   <= ST_FAILED;
      end
      if (pop) begin
        timer_q <= '0;
      end else if ((state_q == S_WAIT) && (timer_q != '1)) begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmi_engine.sv
// Self-checking bench for riscv_dmi_engine: queue-based reference model plus
// directed scenarios with hand-computed expectations.
module tb_riscv_dmi_engine;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CW    = $clog2(DEPTH + 2);

  logic          clk, rstn;
  logic          upd_valid, cap, dmireset, hardreset;
  logic [AW-1:0] upd_addr;
  logic [DW-1:0] upd_data;
  logic [1:0]    upd_op;
  logic [DW-1:0] cap_data;
  logic [1:0]    cap_op, dmistat;
  logic          busy;
  logic [CW-1:0] pending;

  riscv_dmi_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dmi ();

  riscv_dmi_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .upd_valid_i(upd_valid), .upd_addr_i(upd_addr), .upd_data_i(upd_data), .upd_op_i(upd_op),
    .cap_i(cap), .cap_data_o(cap_data), .cap_op_o(cap_op),
    .dmireset_i(dmireset), .hardreset_i(hardreset),
    .dmi(dmi),
    .dmistat_o(dmistat), .busy_o(busy), .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [1:0] op; } cmd_t;
  cmd_t          mq[$];
  int            m_phase = 0;        // 0 idle, 1 offering request, 2 awaiting response
  int            m_timer = 0;
  logic [1:0]    m_sticky = 0, m_last_op = 0;
  logic [DW-1:0] m_last_data = 0;

  task automatic m_reset();
    mq.delete();
    m_phase = 0; m_timer = 0; m_sticky = 0; m_last_op = 0; m_last_data = 0;
  endtask

  always @(posedge clk or negedge rstn) begin : model
    logic [1:0] s;
    int         size0;
    bit         popped, busy0;
    cmd_t       c;
    if (!rstn || hardreset) m_reset();
    else begin
      s = m_sticky; size0 = mq.size(); popped = 0;
      busy0 = (size0 > 0) || (m_phase != 0);
      case (m_phase)
        0: if (size0 > 0) m_phase = 1;
        1: if (dmi.req_ready) begin
             void'(mq.pop_front()); popped = 1; m_timer = 0; m_phase = 2;
           end
        default: begin
          if (dmi.resp_valid) begin
            m_last_data = dmi.resp_data; m_last_op = dmi.resp_op;
            if (s == 0 && dmi.resp_op != 0) s = dmi.resp_op;
            m_phase = 0;
          end else if (TMO != 0 && m_timer == TMO - 1) begin
            m_last_op = 2;
            if (s == 0) s = 2;
            m_phase = 0;
          end else m_timer++;
        end
      endcase
      if (upd_valid && m_sticky == 0) begin
        if (upd_op == 3) begin
          if (s == 0) s = 2;
        end else if (upd_op != 0) begin
          if (size0 == DEPTH && !popped) begin
            if (s == 0) s = 3;
          end else begin
            c.addr = upd_addr; c.data = upd_data; c.op = upd_op;
            mq.push_back(c);
          end
        end
      end
      if (cap && busy0 && m_sticky == 0 && s == 0) s = 3;
      if (dmireset) s = 0;
      m_sticky = s;
    end
  end

  always @(negedge clk) begin : compare
    bit   rq, mb;
    if (cmp_en) begin
      rq = (m_phase == 1);
      mb = (mq.size() > 0) || (m_phase != 0);
      chk("req_valid",  dmi.req_valid,  rq);
      chk("req_addr",   dmi.req_addr,   rq ? mq[0].addr : '0);
      chk("req_data",   dmi.req_data,   rq ? mq[0].data : '0);
      chk("req_op",     dmi.req_op,     rq ? mq[0].op : 2'd0);
      chk("resp_ready", dmi.resp_ready, m_phase != 1);
      chk("busy",       busy,           mb);
      chk("pending",    pending,        mq.size() + ((m_phase != 0) ? 1 : 0));
      chk("dmistat",    dmistat,        m_sticky);
      chk("cap_data",   cap_data,       m_last_data);
      chk("cap_op",     cap_op,         (m_sticky != 0) ? m_sticky : (mb ? 2'd3 : m_last_op));
    end
  end

  // ---------------- handshake monitor ----------------
  logic [AW-1:0] hs_q[$];
  int            hs_cnt = 0;
  always @(posedge clk)
    if (rstn && dmi.req_valid && dmi.req_ready) begin
      hs_q.push_back(dmi.req_addr);
      hs_cnt++;
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_cnt < target && n < 40) begin tick(); n++; end
    chk("handshake_wait", hs_cnt >= target, 1);
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    upd_valid = 1; upd_op = op; upd_addr = a; upd_data = d;
    tick();
    upd_valid = 0;
  endtask

  task automatic respond(input logic [1:0] op, input logic [DW-1:0] d);
    dmi.resp_valid = 1; dmi.resp_op = op; dmi.resp_data = d;
    tick();
    dmi.resp_valid = 0;
  endtask

  task automatic pulse_dmireset();
    dmireset = 1; tick(); dmireset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    rstn = 1; upd_valid = 0; upd_addr = 0; upd_data = 0; upd_op = 0;
    cap = 0; dmireset = 0; hardreset = 0;
    dmi.req_ready = 0; dmi.resp_valid = 0; dmi.resp_data = 0; dmi.resp_op = 0;
    #2 rstn = 0;
    cmp_en = 1;
    tick(); tick();
    chk("rst_req_valid",  dmi.req_valid, 0);
    chk("rst_resp_ready", dmi.resp_ready, 1);
    chk("rst_pending",    pending, 0);
    chk("rst_cap_op",     cap_op, 0);
    rstn = 1;
    tick();

    // single read, DM ready immediately
    dmi.req_ready = 1;
    send(2'd1, 7'h11, 32'h0);
    chk("lat_n1_req_valid", dmi.req_valid, 0);
    tick();
    chk("lat_n2_req_valid", dmi.req_valid, 1);
    chk("lat_n2_req_addr",  dmi.req_addr, 7'h11);
    chk("lat_n2_req_op",    dmi.req_op, 1);
    tick();
    respond(2'd0, 32'hDEADBEEF);
    chk("rd_cap_data", cap_data, 32'hDEADBEEF);
    chk("rd_cap_op",   cap_op, 0);
    chk("rd_pending",  pending, 0);

    // overflow: five writes with DM stalled
    dmi.req_ready = 0;
    tick();
    for (int i = 0; i < 5; i++) send(2'd2, 7'(8'h20 + i), 32'h100 + i);
    chk("ovf_dmistat", dmistat, 3);
    chk("ovf_pending", pending, 5);
    pulse_dmireset();
    chk("ovf_clr_dmistat", dmistat, 0);
    base = hs_cnt;
    dmi.req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      wait_hs(base + k + 1);
      respond(2'd0, 32'hC0 + k);
    end
    for (int i = 0; i < 4; i++) chk("ovf_order", hs_q[base + i], 7'(8'h20 + i));
    chk("ovf_drain_pending", pending, 0);

    // capture too early during WAIT
    base = hs_cnt;
    send(2'd1, 7'h30, 32'h0);
    wait_hs(base + 1);
    chk("cap_busy_op", cap_op, 3);
    cap = 1; tick(); cap = 0;
    chk("cap_sticky", dmistat, 3);
    send(2'd2, 7'h31, 32'h1);
    tick();
    chk("cap_upd_ignored", pending, 1);
    respond(2'd0, 32'h55);
    chk("cap_hidden_op", cap_op, 3);
    chk("cap_data_55",   cap_data, 32'h55);
    pulse_dmireset();
    chk("cap_clr_dmistat", dmistat, 0);
    chk("cap_clr_pending", pending, 0);

    // timeout: DM never answers
    base = hs_cnt;
    send(2'd1, 7'h40, 32'h0);
    wait_hs(base + 1);
    repeat (15) tick();
    chk("tmo_still_wait", pending, 1);
    tick();
    chk("tmo_idle",    pending, 0);
    chk("tmo_cap_op",  cap_op, 2);
    chk("tmo_dmistat", dmistat, 2);
    respond(2'd0, 32'h12345678);
    chk("tmo_late_data", cap_data, 32'h55);
    pulse_dmireset();
    chk("tmo_last_op", cap_op, 2);

    // failed response then success: sticky holds
    base = hs_cnt;
    send(2'd1, 7'h50, 32'h0);
    send(2'd1, 7'h51, 32'h0);
    wait_hs(base + 1);
    respond(2'd2, 32'hA);
    chk("err_dmistat", dmistat, 2);
    wait_hs(base + 2);
    respond(2'd0, 32'hB);
    chk("err_sticky",  dmistat, 2);
    chk("err_cap_op",  cap_op, 2);
    chk("err_cap_data", cap_data, 32'hB);
    pulse_dmireset();
    chk("err_clr_cap_op", cap_op, 0);

    // hardreset during REQ with three queued
    dmi.req_ready = 0;
    send(2'd2, 7'h60, 32'h6);
    send(2'd2, 7'h61, 32'h7);
    send(2'd2, 7'h62, 32'h8);
    tick();
    chk("hr_pre_valid",   dmi.req_valid, 1);
    chk("hr_pre_pending", pending, 4);
    hardreset = 1; tick(); hardreset = 0;
    chk("hr_req_valid", dmi.req_valid, 0);
    chk("hr_pending",   pending, 0);
    chk("hr_busy",      busy, 0);
    chk("hr_dmistat",   dmistat, 0);

    // async reset mid-WAIT
    dmi.req_ready = 1;
    base = hs_cnt;
    send(2'd1, 7'h70, 32'h0);
    wait_hs(base + 1);
    cap = 1; tick(); cap = 0;
    #2 rstn = 0;
    #1;
    chk("ar_dmistat",    dmistat, 0);
    chk("ar_cap_op",     cap_op, 0);
    chk("ar_pending",    pending, 0);
    chk("ar_busy",       busy, 0);
    chk("ar_resp_ready", dmi.resp_ready, 1);
    chk("ar_req_valid",  dmi.req_valid, 0);
    tick(); tick();
    rstn = 1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/riscv_dmi_engine.md
Name: riscv_dmi_engine

Overview:
- Parametrised, single-clock DMI transaction engine between a DTM scan front-end (commands already synchronised into the system clock) and the Debug Module.
- Queues up to REQ_DEPTH DMI commands and issues them in order over a valid/ready request/response channel.
- Maintains the sticky dmistat error, reports busy/last-result for capture, and adds a response timeout, which the previous single-outstanding DTM lacked.

Parameters:
ADDR_WIDTH, 7, DMI address bits (abits)
DATA_WIDTH, 32, DMI data bits
REQ_DEPTH, 4, command queue entries; power of two, >=1
TIMEOUT_CYCLES, 1024, cycles in WAIT before forced FAILED; 0 disables timeout
CNT_WIDTH, $clog2(REQ_DEPTH+2), width of pending_o

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset; asynchronous, active-low
upd_valid_i  in  1  one-cycle strobe: new DMI command from scan update
upd_addr_i  in  ADDR_WIDTH  command address
upd_data_i  in  DATA_WIDTH  command write data
upd_op_i  in  2  0 NOP, 1 READ, 2 WRITE, 3 reserved
cap_i  in  1  one-cycle strobe: scan capture of dmi register
cap_data_o  out  DATA_WIDTH  data presented for capture
cap_op_o  out  2  op presented for capture: 0 SUCCESS, 2 FAILED, 3 BUSY
dmireset_i  in  1  one-cycle strobe: clear sticky status
hardreset_i  in  1  one-cycle strobe: abort everything
req_valid_o  out  1  request valid to DM
req_ready_i  in  1  DM accepts request
req_addr_o  out  ADDR_WIDTH  request address
req_data_o  out  DATA_WIDTH  request data
req_op_o  out  2  request op (1 or 2 only)
resp_valid_i  in  1  DM response valid
resp_ready_o  out  1  engine accepts response
resp_data_i  in  DATA_WIDTH  response data
resp_op_i  in  2  response op
dmistat_o  out  2  current sticky status (for dtmcs)
busy_o  out  1  queue non-empty or transaction in flight
pending_o  out  CNT_WIDTH  queued entries + in-flight (0..REQ_DEPTH+1)

Behaviour:
- Reset (rstn_i low, async): queue empty, FSM IDLE, sticky=0, last_op=0, last_data=0, timer=0; all outputs 0 except resp_ready_o=1.
- Enqueue on upd_valid_i:
  - dropped if sticky!=0;
  - op 0 (NOP): dropped, no status change;
  - op 3: dropped, sticky<=2;
  - queue full and no pop this cycle: dropped, sticky<=3;
  - otherwise pushed. Full+pop same cycle accepts the push.
- FSM:
  - IDLE: resp_ready_o=1; stray responses are accepted and discarded. If queue non-empty, go to REQ next cycle.
  - REQ: req_valid_o=1; req_* driven from the queue head, stable until handshake; resp_ready_o=0. On req_ready_i: pop head, timer<=0, go to WAIT.
  - WAIT: resp_ready_o=1; timer increments. On resp_valid_i: last_data<=resp_data_i, last_op<=resp_op_i; if resp_op_i!=0 and sticky==0 then sticky<=resp_op_i; go to IDLE.
  - Timeout: if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 without a response, then last_op<=2, sticky<=2 if 0, go to IDLE. A late response is later discarded in IDLE.
  - Response and timeout in the same cycle: response wins.
- Minimum latency: upd_valid_i at cycle N gives req_valid_o high at N+2 (empty queue, IDLE).
- Capture (combinational from registered state):
  - cap_data_o=last_data.
  - cap_op_o = sticky if sticky!=0; else 3 if busy_o; else last_op.
  - cap_i while busy_o and sticky==0 sets sticky<=3 (host scanned too early).
- dmireset_i: sticky<=0. Wins over any sticky set in the same cycle. Queue and FSM are unaffected.
- hardreset_i: same state as reset, synchronously, next edge. Overrides every other event that cycle, including an in-progress REQ (req_valid_o drops without handshake) and WAIT (the response is later discarded).
- dmistat_o=sticky.
- pending_o = queue count + (FSM!=IDLE ? 1 : 0).
- Counters never wrap: queue pointers are log2(REQ_DEPTH) bits with a separate count; timer saturates.

Test Plan:
- Single read, DM ready immediately, resp data 0xDEADBEEF op 0 -> req_valid_o at N+2, addr/op match; cap_op_o=0, cap_data_o=0xDEADBEEF, pending_o returns to 0.
- REQ_DEPTH=4, five writes back-to-back with req_ready_i=0 -> four accepted, fifth dropped, dmistat_o=3; after dmireset_i, dmistat_o=0 and four requests issue in order.
- Capture during WAIT -> cap_op_o=3 and sticky=3; next update is ignored (pending_o unchanged) until dmireset_i.
- TIMEOUT_CYCLES=16, DM never responds -> at 16 cycles in WAIT, FSM is IDLE, cap_op_o=2; a late resp_valid_i is accepted and last_data is unchanged.
- Response op 2 followed by a successful transaction -> dmistat_o stays 2 (sticky), last_op=0 is hidden by sticky until dmireset_i.
- hardreset_i asserted during REQ with 3 queued -> next cycle req_valid_o=0, pending_o=0, busy_o=0, dmistat_o=0; rstn_i low mid-WAIT -> all outputs reset immediately.
